// File: rtl/ifetch_responder.sv
// Memory-side responder for the two per-core icaches: round-robin arbitration,
// one-word RAM reads that defer to data-side traffic, and a sticky watchdog error.
module ifetch_responder #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int TO_W = 8
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic [1:0]    iREN,
    input  logic [AW-1:0] iaddr0,
    input  logic [AW-1:0] iaddr1,
    output logic [1:0]    iwait,
    output logic [DW-1:0] iload0,
    output logic [DW-1:0] iload1,
    input  logic          dbusy,
    output logic          ram_ren,
    output logic [AW-1:0] ram_addr,
    input  logic          ram_rdy,
    input  logic [DW-1:0] ram_rdata,
    output logic          ibusy,
    output logic          ierr
);

    // state  | meaning
    // IDLE   | waiting for a request while the data side is quiet
    // ACCESS | RAM read outstanding for the owner, watchdog running
    // RESP   | one-cycle response to the owner (suppressed if it withdrew)
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [TO_W-1:0] WD_MAX = '1;

    state_t          state;
    logic            owner;
    logic            last_grant;
    logic [TO_W-1:0] wdog;
    logic            pick;
    logic            done;
    logic [DW-1:0]   rsp_data;

    always_comb begin
        pick = iREN[1];
        if (iREN == 2'b11) pick = ~last_grant;
    end

    // Timeout completes the transaction with a zero word so the owner never hangs.
    assign done     = ram_rdy || (wdog == WD_MAX);
    assign rsp_data = ram_rdy ? ram_rdata : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            iwait      <= 2'b11;
            iload0     <= '0;
            iload1     <= '0;
            ram_ren    <= 1'b0;
            ram_addr   <= '0;
            ibusy      <= 1'b0;
            ierr       <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wdog       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!dbusy && iREN != 2'b00) begin
                        owner    <= pick;
                        ram_addr <= pick ? iaddr1 : iaddr0;
                        ram_ren  <= 1'b1;
                        ibusy    <= 1'b1;
                        wdog     <= '0;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (done) begin
                        if (!ram_rdy) ierr <= 1'b1;
                        ram_ren <= 1'b0;
                        state   <= RESP;
                        if (iREN[owner]) begin
                            iwait[owner] <= 1'b0;
                            if (owner) iload1 <= rsp_data;
                            else       iload0 <= rsp_data;
                        end
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    iwait      <= 2'b11;
                    iload0     <= '0;
                    iload1     <= '0;
                    last_grant <= owner;
                    wdog       <= '0;
                    ibusy      <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder: per-cycle vector table plus hand-written
// sequences for the watchdog timeout and mid-transaction reset.
module tb_ifetch_responder;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [1:0]  iREN = 2'b00;
    logic [31:0] iaddr0 = '0, iaddr1 = '0;
    logic [1:0]  iwait;
    logic [31:0] iload0, iload1;
    logic        dbusy = 1'b0;
    logic        ram_ren;
    logic [31:0] ram_addr;
    logic        ram_rdy = 1'b0;
    logic [31:0] ram_rdata = '0;
    logic        ibusy, ierr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    ifetch_responder dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr0(iaddr0), .iaddr1(iaddr1),
        .iwait(iwait), .iload0(iload0), .iload1(iload1), .dbusy(dbusy),
        .ram_ren(ram_ren), .ram_addr(ram_addr), .ram_rdy(ram_rdy),
        .ram_rdata(ram_rdata), .ibusy(ibusy), .ierr(ierr)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  iren;
        logic [31:0] a0, a1;
        logic        dbusy, rdy;
        logic [31:0] rdata;
        logic [1:0]  e_iwait;
        logic [31:0] e_l0, e_l1;
        logic        e_ren;
        logic [31:0] e_addr;
        logic        e_busy;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        iREN = 2'b00; dbusy = 1'b0; ram_rdy = 1'b0; ram_rdata = '0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    function automatic void add(logic rst, logic [1:0] iren, logic [31:0] a0, logic [31:0] a1,
                                logic db, logic rdy, logic [31:0] rdata, logic [1:0] e_iwait,
                                logic [31:0] e_l0, logic [31:0] e_l1, logic e_ren,
                                logic [31:0] e_addr, logic e_busy);
        vec_t v;
        v.rst = rst; v.iren = iren; v.a0 = a0; v.a1 = a1; v.dbusy = db; v.rdy = rdy;
        v.rdata = rdata; v.e_iwait = e_iwait; v.e_l0 = e_l0; v.e_l1 = e_l1;
        v.e_ren = e_ren; v.e_addr = e_addr; v.e_busy = e_busy;
        vt.push_back(v);
    endfunction

    int n;

    initial begin
        // single core 0 fetch, minimum latency
        add(1, 2'b01, 32'h40, 32'h0, 0, 0, 32'h0,        2'b11, 0, 0, 1, 32'h40, 1);
        add(0, 2'b01, 32'h40, 32'h0, 0, 1, 32'h24080001, 2'b10, 32'h24080001, 0, 0, 0, 1);
        add(0, 2'b00, 32'h40, 32'h0, 0, 0, 32'h0,        2'b11, 0, 0, 0, 0, 0);
        // simultaneous requests after reset: core0, core1, then core0 again
        add(1, 2'b11, 32'h100, 32'h200, 0, 0, 32'h0,        2'b11, 0, 0, 1, 32'h100, 1);
        add(0, 2'b11, 32'h100, 32'h200, 0, 1, 32'hAAAA0000, 2'b10, 32'hAAAA0000, 0, 0, 0, 1);
        add(0, 2'b10, 32'h100, 32'h200, 0, 0, 32'h0,        2'b11, 0, 0, 0, 0, 0);
        add(0, 2'b10, 32'h100, 32'h200, 0, 0, 32'h0,        2'b11, 0, 0, 1, 32'h200, 1);
        add(0, 2'b10, 32'h100, 32'h200, 0, 1, 32'hBBBB1111, 2'b01, 0, 32'hBBBB1111, 0, 0, 1);
        add(0, 2'b00, 32'h100, 32'h200, 0, 0, 32'h0,        2'b11, 0, 0, 0, 0, 0);
        add(0, 2'b11, 32'h100, 32'h200, 0, 0, 32'h0,        2'b11, 0, 0, 1, 32'h100, 1);
        add(0, 2'b11, 32'h100, 32'h200, 0, 1, 32'hCCCC2222, 2'b10, 32'hCCCC2222, 0, 0, 0, 1);
        add(0, 2'b00, 32'h100, 32'h200, 0, 1, 32'hFFFF0000, 2'b11, 0, 0, 0, 0, 0);
        add(0, 2'b00, 32'h100, 32'h200, 0, 1, 32'h12345678, 2'b11, 0, 0, 0, 0, 0);
        // dbusy blocks core1 for 5 cycles, then rises mid-transaction
        for (int i = 0; i < 5; i++)
            add(0, 2'b10, 32'h100, 32'h300, 1, 0, 32'h0, 2'b11, 0, 0, 0, 0, 0);
        add(0, 2'b10, 32'h100, 32'h300, 0, 0, 32'h0,        2'b11, 0, 0, 1, 32'h300, 1);
        add(0, 2'b10, 32'h100, 32'h300, 1, 0, 32'h0,        2'b11, 0, 0, 1, 32'h300, 1);
        add(0, 2'b10, 32'h100, 32'h300, 1, 1, 32'hDDDD3333, 2'b01, 0, 32'hDDDD3333, 0, 0, 1);
        add(0, 2'b00, 32'h100, 32'h300, 1, 0, 32'h0,        2'b11, 0, 0, 0, 0, 0);
        add(0, 2'b00, 32'h100, 32'h300, 0, 0, 32'h0,        2'b11, 0, 0, 0, 0, 0);
        // address change ignored, owner withdraws, last_grant still advances
        add(0, 2'b01, 32'h40, 32'h300, 0, 0, 32'h0,        2'b11, 0, 0, 1, 32'h40, 1);
        add(0, 2'b01, 32'h80, 32'h300, 0, 0, 32'h0,        2'b11, 0, 0, 1, 32'h40, 1);
        add(0, 2'b00, 32'h80, 32'h300, 0, 0, 32'h0,        2'b11, 0, 0, 1, 32'h40, 1);
        add(0, 2'b00, 32'h80, 32'h300, 0, 1, 32'hEEEE4444, 2'b11, 0, 0, 0, 0, 1);
        add(0, 2'b00, 32'h80, 32'h300, 0, 0, 32'h0,        2'b11, 0, 0, 0, 0, 0);
        add(0, 2'b11, 32'h80, 32'h500, 0, 0, 32'h0,        2'b11, 0, 0, 1, 32'h500, 1);
        add(0, 2'b11, 32'h80, 32'h500, 0, 1, 32'h55556666, 2'b01, 0, 32'h55556666, 0, 0, 1);
        add(0, 2'b00, 32'h80, 32'h500, 0, 0, 32'h0,        2'b11, 0, 0, 0, 0, 0);

        do_reset();
        chk("rst_iwait", {30'b0, iwait}, 32'h3);
        chk("rst_iload0", iload0, 32'h0);
        chk("rst_iload1", iload1, 32'h0);
        chk("rst_ren", {31'b0, ram_ren}, 32'h0);
        chk("rst_addr", ram_addr, 32'h0);
        chk("rst_ibusy", {31'b0, ibusy}, 32'h0);
        chk("rst_ierr", {31'b0, ierr}, 32'h0);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) do_reset();
            iREN = vt[i].iren; iaddr0 = vt[i].a0; iaddr1 = vt[i].a1;
            dbusy = vt[i].dbusy; ram_rdy = vt[i].rdy; ram_rdata = vt[i].rdata;
            tick();
            chk($sformatf("v%0d_iwait", i), {30'b0, iwait}, {30'b0, vt[i].e_iwait});
            chk($sformatf("v%0d_iload0", i), iload0, vt[i].e_l0);
            chk($sformatf("v%0d_iload1", i), iload1, vt[i].e_l1);
            chk($sformatf("v%0d_ren", i), {31'b0, ram_ren}, {31'b0, vt[i].e_ren});
            chk($sformatf("v%0d_ibusy", i), {31'b0, ibusy}, {31'b0, vt[i].e_busy});
            if (vt[i].e_ren) chk($sformatf("v%0d_addr", i), ram_addr, vt[i].e_addr);
        end

        // watchdog: RAM never answers; 256 ACCESS cycles (counter 0..255) then zero response
        do_reset();
        iREN = 2'b01; iaddr0 = 32'h600;
        tick();
        chk("wd_grant", {31'b0, ram_ren}, 32'h1);
        n = 0;
        while (iwait == 2'b11 && n < 300) begin
            tick();
            n++;
        end
        chk("wd_cycles", n, 256);
        chk("wd_iwait", {30'b0, iwait}, 32'h2);
        chk("wd_iload0", iload0, 32'h0);
        chk("wd_ierr", {31'b0, ierr}, 32'h1);
        iREN = 2'b00;
        repeat (3) tick();
        chk("wd_ierr_sticky", {31'b0, ierr}, 32'h1);
        chk("wd_idle", {31'b0, ibusy}, 32'h0);
        do_reset();
        chk("wd_ierr_clr", {31'b0, ierr}, 32'h0);

        // reset mid-ACCESS, then a fresh request
        iREN = 2'b01; iaddr0 = 32'h700;
        tick();
        chk("mr_access", {31'b0, ram_ren}, 32'h1);
        #2 nRST = 1'b0;
        #1;
        chk("mr_ren", {31'b0, ram_ren}, 32'h0);
        chk("mr_iwait", {30'b0, iwait}, 32'h3);
        chk("mr_ibusy", {31'b0, ibusy}, 32'h0);
        tick();
        nRST = 1'b1; iaddr0 = 32'h704;
        tick();
        chk("mr_addr", ram_addr, 32'h704);
        ram_rdy = 1'b1; ram_rdata = 32'h77;
        tick();
        ram_rdy = 1'b0;
        chk("mr_iwait2", {30'b0, iwait}, 32'h2);
        chk("mr_iload0", iload0, 32'h77);
        iREN = 2'b00;
        tick();
        chk("mr_done", {30'b0, iwait}, 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
